// File: rtl/op_mult_pkg.sv
// ---------------------------------------------------------------------------
// op_mult_pkg
// Shared constants, types and helpers for the pipelined fixed-point
// multiplier family (op_mult_pipe and the reusable round/saturate stage).
//   BOUND_W     : width of the saturation bound constants (max OUT_W)
//   MAX_STAGES  : widest stage-valid vector supported
//   stage_vld_t : stage-valid vector, bit k = stage k+1 holds valid data
//   bounds_t    : max/min result constants for a given output format
// ---------------------------------------------------------------------------
package op_mult_pkg;

  localparam int BOUND_W    = 64;
  localparam int MAX_STAGES = 32;

  typedef logic [MAX_STAGES-1:0] stage_vld_t;

  typedef struct packed {
    logic [BOUND_W-1:0] max_v;
    logic [BOUND_W-1:0] min_v;
  } bounds_t;

  // Largest and smallest representable result for an out_w-bit format.
  // The signed minimum is kept sign-extended so its low out_w bits are 10..0.
  function automatic bounds_t sat_bounds(input int out_w, input bit is_signed);
    bounds_t bnd;
    bnd.max_v = '0;
    bnd.min_v = '0;
    if (is_signed) begin
      bnd.max_v = (BOUND_W'(1) << (out_w - 1)) - BOUND_W'(1);
      bnd.min_v = ~bnd.max_v;
    end else if (out_w >= BOUND_W) begin
      bnd.max_v = '1;
    end else begin
      bnd.max_v = (BOUND_W'(1) << out_w) - BOUND_W'(1);
    end
    return bnd;
  endfunction

  // Advance a stage-valid vector by one stage, inserting the new entry bit.
  function automatic stage_vld_t vld_shift(input stage_vld_t v, input logic in_bit);
    return {v[MAX_STAGES-2:0], in_bit};
  endfunction

endpackage

// File: rtl/op_mult_round_sat.sv
// ---------------------------------------------------------------------------
// op_mult_round_sat
// Combinational post-multiply stage: optional round-half-up, right shift by
// FRAC (arithmetic when SIGNED), range check against OUT_W, then saturate or
// wrap. Reusable by any block that produces a full-width product.
//   prod_i : full product, PROD_W bits (two's complement when SIGNED)
//   res_o  : scaled result, OUT_W bits
//   ov_o   : scaled value did not fit in OUT_W
// ---------------------------------------------------------------------------
module op_mult_round_sat
  import op_mult_pkg::*;
#(
  parameter int PROD_W   = 32,
  parameter int OUT_W    = 16,
  parameter int FRAC     = 15,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int ROUND    = 1
) (
  input  logic [PROD_W-1:0] prod_i,
  output logic [OUT_W-1:0]  res_o,
  output logic              ov_o
);

  // One guard bit so the rounding add can never wrap.
  localparam int QW     = PROD_W + 1;
  localparam int EW     = (OUT_W > QW) ? OUT_W : QW;
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [QW-1:0] RND_C = (ROUND != 0 && FRAC > 0) ? (QW'(1) << RND_SH) : '0;

  localparam bounds_t           BND   = sat_bounds(OUT_W, SIGNED != 0);
  localparam logic [OUT_W-1:0]  MAX_V = BND.max_v[OUT_W-1:0];
  localparam logic [OUT_W-1:0]  MIN_V = BND.min_v[OUT_W-1:0];

  logic [QW-1:0]        q;
  logic signed [QW-1:0] qs;
  logic [QW-1:0]        sh;
  logic signed [QW-1:0] shs;
  logic [EW-1:0]        shx;
  logic                 out_of_range;

  // Shift is done through signed temporaries so >>> really is arithmetic;
  // mixing signed and unsigned in one expression would silently make it logical.
  always_comb begin
    q   = {((SIGNED != 0) & prod_i[PROD_W-1]), prod_i} + RND_C;
    qs  = q;
    if (SIGNED != 0) sh = qs >>> FRAC;
    else             sh = q >> FRAC;
    shs = sh;
    if (SIGNED != 0) shx = EW'(shs);
    else             shx = EW'(sh);
  end

  generate
    if (OUT_W >= QW) begin : g_fits
      assign out_of_range = 1'b0;
    end else if (SIGNED != 0) begin : g_signed_chk
      // Fits when every bit from the result's sign bit upward agrees.
      assign out_of_range = !((&shx[EW-1:OUT_W-1]) || !(|shx[EW-1:OUT_W-1]));
    end else begin : g_unsigned_chk
      assign out_of_range = |shx[EW-1:OUT_W];
    end
  endgenerate

  always_comb begin
    res_o = shx[OUT_W-1:0];
    ov_o  = out_of_range;
    if (out_of_range && SATURATE != 0) begin
      res_o = ((SIGNED != 0) && shx[EW-1]) ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/op_mult_pipe.sv
// ---------------------------------------------------------------------------
// op_mult_pipe
// Pipelined fixed-point multiplier with valid/ready on both sides, Q-format
// scaling, optional rounding, saturate-or-wrap and overflow flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready depends only on state
//                         and out_ready)
//   a, b                : operands (A_W, B_W bits)
//   out_valid/out_ready : result handshake
//   result, ov          : scaled product and its overflow flag
//   ov_sticky, ov_clr   : accumulated overflow flag and its synchronous clear
// Stages: 1 = operand regs, 2 = full product, 3 = round/shift/saturate,
// 4..STAGES = plain delay.
// ---------------------------------------------------------------------------
module op_mult_pipe
  import op_mult_pkg::*;
#(
  parameter int A_W      = 16,
  parameter int B_W      = 16,
  parameter int OUT_W    = 16,
  parameter int FRAC     = 15,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int ROUND    = 1,
  parameter int STAGES   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ov,
  output logic             ov_sticky,
  input  logic             ov_clr
);

  localparam int PROD_W = A_W + B_W;
  localparam int NR     = STAGES - 2;

  generate
    if (STAGES < 3 || STAGES > MAX_STAGES || FRAC < 0 || FRAC >= PROD_W || OUT_W > BOUND_W)
    begin : g_cfg_err
      $error("op_mult_pipe: illegal parameters (STAGES=%0d FRAC=%0d OUT_W=%0d)",
             STAGES, FRAC, OUT_W);
    end
  endgenerate

  logic                 adv;
  logic [STAGES-1:0]    vld_q, vld_d;
  logic [A_W-1:0]       a_q;
  logic [B_W-1:0]       b_q;
  logic [PROD_W-1:0]    a_ext, b_ext, prod_d, prod_q;
  logic [OUT_W-1:0]     rs_res, res3_q;
  logic                 rs_ov, ov3_q;
  logic                 ov_sticky_q, ov_sticky_d;
  logic [OUT_W-1:0]     chain_res [NR];
  logic                 chain_ov  [NR];

  // Whole pipe moves together unless the output is full and not being taken.
  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Operands are extended to the product width, so the low PROD_W bits of a
  // plain multiply give the correct signed or unsigned product.
  always_comb begin
    a_ext  = {{B_W{(SIGNED != 0) & a_q[A_W-1]}}, a_q};
    b_ext  = {{A_W{(SIGNED != 0) & b_q[B_W-1]}}, b_q};
    prod_d = a_ext * b_ext;
    vld_d  = STAGES'(vld_shift(stage_vld_t'(vld_q), in_valid));
  end

  op_mult_round_sat #(
    .PROD_W   (PROD_W),
    .OUT_W    (OUT_W),
    .FRAC     (FRAC),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE),
    .ROUND    (ROUND)
  ) u_round_sat (
    .prod_i (prod_q),
    .res_o  (rs_res),
    .ov_o   (rs_ov)
  );

  // Set beats clear when an overflowing result is taken in the same cycle.
  always_comb begin
    ov_sticky_d = ov_sticky_q;
    if (ov_clr) ov_sticky_d = 1'b0;
    if (out_valid && out_ready && ov) ov_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      res3_q      <= '0;
      ov3_q       <= 1'b0;
      ov_sticky_q <= 1'b0;
    end else begin
      ov_sticky_q <= ov_sticky_d;
      if (adv) begin
        vld_q  <= vld_d;
        a_q    <= a;
        b_q    <= b;
        prod_q <= prod_d;
        res3_q <= rs_res;
        ov3_q  <= rs_ov;
      end
    end
  end

  assign chain_res[0] = res3_q;
  assign chain_ov[0]  = ov3_q;

  for (genvar k = 1; k < NR; k++) begin : g_dly
    logic [OUT_W-1:0] dly_res_q;
    logic             dly_ov_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_res_q <= '0;
        dly_ov_q  <= 1'b0;
      end else if (adv) begin
        dly_res_q <= chain_res[k-1];
        dly_ov_q  <= chain_ov[k-1];
      end
    end

    assign chain_res[k] = dly_res_q;
    assign chain_ov[k]  = dly_ov_q;
  end

  assign out_valid = vld_q[STAGES-1];
  assign result    = chain_res[NR-1];
  assign ov        = chain_ov[NR-1];
  assign ov_sticky = ov_sticky_q;

endmodule

// File: tb/tb_op_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_op_mult_pipe
// Four multiplier configurations share one operand stream:
//   0: signed Q15, saturate, round      1: signed Q15, wrap, truncate
//   2: unsigned, FRAC=0, 16-bit out     3: unsigned, FRAC=0, 32-bit out
// A negedge monitor scores every result against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_op_mult_pipe;

  typedef struct {
    bit sgn;
    int outW;
    int frac;
    bit sat;
    bit rnd;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b1;
  logic        ovClr = 1'b0;
  logic [15:0] aIn = '0;
  logic [15:0] bIn = '0;

  logic [3:0]  inReady, outValid, ovOut, ovSticky;
  logic [15:0] res0, res1, res2;
  logic [31:0] res3;
  logic [31:0] resAll [4];

  cfg_t        cfgs [4];
  logic [31:0] pendQ [4][$];
  logic [31:0] lastRes [4];
  logic        lastOv [4];
  logic        stickyExp [4];
  logic        prevStall [4];
  logic [31:0] prevRes [4];
  logic        prevOv [4];
  int          outCount [4];

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  op_mult_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .FRAC(15), .SIGNED(1),
                 .SATURATE(1), .ROUND(1), .STAGES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady[0]),
    .a(aIn), .b(bIn), .out_valid(outValid[0]), .out_ready(outReady),
    .result(res0), .ov(ovOut[0]), .ov_sticky(ovSticky[0]), .ov_clr(ovClr));

  op_mult_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .FRAC(15), .SIGNED(1),
                 .SATURATE(0), .ROUND(0), .STAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady[1]),
    .a(aIn), .b(bIn), .out_valid(outValid[1]), .out_ready(outReady),
    .result(res1), .ov(ovOut[1]), .ov_sticky(ovSticky[1]), .ov_clr(ovClr));

  op_mult_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .FRAC(0), .SIGNED(0),
                 .SATURATE(1), .ROUND(1), .STAGES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady[2]),
    .a(aIn), .b(bIn), .out_valid(outValid[2]), .out_ready(outReady),
    .result(res2), .ov(ovOut[2]), .ov_sticky(ovSticky[2]), .ov_clr(ovClr));

  op_mult_pipe #(.A_W(16), .B_W(16), .OUT_W(32), .FRAC(0), .SIGNED(0),
                 .SATURATE(1), .ROUND(1), .STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady[3]),
    .a(aIn), .b(bIn), .out_valid(outValid[3]), .out_ready(outReady),
    .result(res3), .ov(ovOut[3]), .ov_sticky(ovSticky[3]), .ov_clr(ovClr));

  assign resAll[0] = {16'h0, res0};
  assign resAll[1] = {16'h0, res1};
  assign resAll[2] = {16'h0, res2};
  assign resAll[3] = res3;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, add half an LSB, floor-divide by
  // 2^frac, then clamp or wrap into the output format. Returns {ov, result}.
  function automatic logic [32:0] model(input cfg_t c, input logic [15:0] av, input logic [15:0] bv);
    longint pa, pb, p, q, mx, mn, r;
    logic   ovv;
    if (c.sgn) begin
      pa = longint'($signed(av));
      pb = longint'($signed(bv));
      mx = (longint'(1) << (c.outW - 1)) - 1;
      mn = -(longint'(1) << (c.outW - 1));
    end else begin
      pa = longint'(av);
      pb = longint'(bv);
      mx = (longint'(1) << c.outW) - 1;
      mn = 0;
    end
    p = pa * pb;
    if (c.rnd && c.frac > 0) p = p + (longint'(1) << (c.frac - 1));
    q = p >>> c.frac;
    ovv = (q > mx) || (q < mn);
    r = q;
    if (ovv && c.sat) r = (q > mx) ? mx : mn;
    r = r & ((longint'(1) << c.outW) - 1);
    return {ovv, r[31:0]};
  endfunction

  // Monitor: sampled mid-cycle, so everything seen here is what the next
  // rising edge will act on. Scores handshakes, holds and the sticky flag.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pendQ[i].delete();
        stickyExp[i] = 1'b0;
        prevStall[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] ab;
        logic [32:0] e;
        logic        setSticky;
        setSticky = 1'b0;
        checkOutput($sformatf("in_ready%0d", i), inReady[i], !outValid[i] || outReady);
        checkOutput($sformatf("sticky%0d", i), ovSticky[i], stickyExp[i]);
        if (prevStall[i] && outValid[i]) begin
          checkOutput($sformatf("hold_res%0d", i), resAll[i], prevRes[i]);
          checkOutput($sformatf("hold_ov%0d", i), ovOut[i], prevOv[i]);
        end
        if (outValid[i]) begin
          if (pendQ[i].size() == 0) begin
            checkOutput($sformatf("unexpected_valid%0d", i), outValid[i], 1'b0);
          end else if (outReady) begin
            ab = pendQ[i].pop_front();
            e  = model(cfgs[i], ab[31:16], ab[15:0]);
            checkOutput($sformatf("res%0d a=%h b=%h", i, ab[31:16], ab[15:0]), resAll[i], e[31:0]);
            checkOutput($sformatf("ov%0d a=%h b=%h", i, ab[31:16], ab[15:0]), ovOut[i], e[32]);
            lastRes[i] = resAll[i];
            lastOv[i]  = ovOut[i];
            outCount[i]++;
            setSticky = e[32];
          end
        end
        if (setSticky) stickyExp[i] = 1'b1;
        else if (ovClr) stickyExp[i] = 1'b0;
        prevStall[i] = outValid[i] && !outReady;
        prevRes[i]   = resAll[i];
        prevOv[i]    = ovOut[i];
        if (inValid && inReady[i]) pendQ[i].push_back({aIn, bIn});
      end
    end
  end

  // Drives one cycle of inputs and reports whether instance 0 accepted them.
  task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                               input logic ordy, input logic clr, output logic acc);
    inValid  = v;
    aIn      = av;
    bIn      = bv;
    outReady = ordy;
    ovClr    = clr;
    @(negedge clk);
    acc = inValid && inReady[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic sendOne(input logic [15:0] av, input logic [15:0] bv);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      applyStimulus(1'b1, av, bv, 1'b1, 1'b0, acc);
      n++;
    end
    if (!acc) checkOutput("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic sendAndDrain(input logic [15:0] av, input logic [15:0] bv);
    sendOne(av, bv);
    idle(6);
  endtask

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Safety net so a wedged handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        acc;
    int          lat, base, idx, cyc, n;
    logic [15:0] bpA [8];
    logic [15:0] bpB [8];
    logic        pat [4];

    cfgs[0] = '{sgn: 1'b1, outW: 16, frac: 15, sat: 1'b1, rnd: 1'b1};
    cfgs[1] = '{sgn: 1'b1, outW: 16, frac: 15, sat: 1'b0, rnd: 1'b0};
    cfgs[2] = '{sgn: 1'b0, outW: 16, frac: 0,  sat: 1'b1, rnd: 1'b1};
    cfgs[3] = '{sgn: 1'b0, outW: 32, frac: 0,  sat: 1'b1, rnd: 1'b1};
    for (int i = 0; i < 4; i++) begin
      lastRes[i] = '0; lastOv[i] = 1'b0; outCount[i] = 0;
      prevRes[i] = '0; prevOv[i] = 1'b0;
    end

    // Reset values while held in reset, and ready right after release.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst_valid%0d", i), outValid[i], 1'b0);
      checkOutput($sformatf("rst_res%0d", i), resAll[i], 32'h0);
      checkOutput($sformatf("rst_ov%0d", i), ovOut[i], 1'b0);
      checkOutput($sformatf("rst_sticky%0d", i), ovSticky[i], 1'b0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rst_ready%0d", i), inReady[i], 1'b1);

    // 0.5 * 0.5 in Q15 with latency measured from the accept cycle.
    idle(2);
    applyStimulus(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0, acc);
    checkOutput("lat_accept", acc, 1'b1);
    lat = 1;
    while (!outValid[0] && lat < 10) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'd3);
    idle(5);
    checkOutput("q15_half_res", lastRes[0], 32'h2000);
    checkOutput("q15_half_ov", lastOv[0], 1'b0);

    // -1 * -1 overflows: saturating vs wrapping.
    sendAndDrain(16'h8000, 16'h8000);
    checkOutput("neg1sq_sat_res", lastRes[0], 32'h7FFF);
    checkOutput("neg1sq_sat_ov", lastOv[0], 1'b1);
    checkOutput("neg1sq_wrap_res", lastRes[1], 32'h8000);
    checkOutput("neg1sq_wrap_ov", lastOv[1], 1'b1);
    checkOutput("neg1sq_sticky", ovSticky[0], 1'b1);

    // Rounding of tiny products, positive and negative.
    sendAndDrain(16'h0001, 16'h4000);
    checkOutput("rnd_pos_round", lastRes[0], 32'h0001);
    checkOutput("rnd_pos_trunc", lastRes[1], 32'h0000);
    sendAndDrain(16'hFFFF, 16'h4000);
    checkOutput("rnd_neg_round", lastRes[0], 32'h0000);
    checkOutput("rnd_neg_trunc", lastRes[1], 32'hFFFF);

    // Unsigned integer product against 16- and 32-bit outputs.
    sendAndDrain(16'h0100, 16'h0100);
    checkOutput("uns16_res", lastRes[2], 32'hFFFF);
    checkOutput("uns16_ov", lastOv[2], 1'b1);
    checkOutput("uns32_res", lastRes[3], 32'h0001_0000);
    checkOutput("uns32_ov", lastOv[3], 1'b0);

    // Clear, then clear again exactly when an overflowing result is taken.
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, acc);
    checkOutput("sticky_cleared", ovSticky[0], 1'b0);
    applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
    checkOutput("clr_align_valid", outValid[0], 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, acc);
    checkOutput("sticky_set_wins", ovSticky[0], 1'b1);
    idle(3);

    // Random traffic with random backpressure and occasional clears.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 9) < 7, pickOperand(), pickOperand(),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, acc);
    end
    idle(6);

    // Eight back-to-back operands against a 1,0,0,1 consumer pattern.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bpA[k] = pickOperand();
      bpB[k] = pickOperand();
    end
    base = outCount[0];
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      applyStimulus(1'b1, bpA[idx], bpB[idx], pat[cyc % 4], 1'b0, acc);
      if (acc) idx++;
      cyc++;
    end
    checkOutput("bp_accepted", 64'(idx), 64'd8);
    n = 0;
    while (pendQ[0].size() > 0 && n < 100) begin
      applyStimulus(1'b0, 16'h0, 16'h0, pat[cyc % 4], 1'b0, acc);
      cyc++;
      n++;
    end
    checkOutput("bp_count", 64'(outCount[0] - base), 64'd8);
    idle(4);

    // Reset with two operands in flight discards them and the sticky flag.
    sendAndDrain(16'h8000, 16'h8000);
    checkOutput("sticky_pre_rst", ovSticky[0], 1'b1);
    applyStimulus(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, acc);
    inValid = 1'b0;
    base = outCount[0];
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) checkOutput($sformatf("midrst_valid%0d", i), outValid[i], 1'b0);
    checkOutput("midrst_sticky", ovSticky[0], 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);
    checkOutput("midrst_no_stale", 64'(outCount[0] - base), 64'd0);

    // Final drain: nothing accepted may be left unanswered.
    idle(6);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("drain%0d", i), 64'(pendQ[i].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
